// File: rtl/sa_enable_sequencer.sv
// Step sequencer for the systolic-array register enables: walks a per-step
// enable pattern table under a start/busy/done handshake with stall, abort and loop.
`timescale 1ns/1ps
module sa_enable_sequencer #(
  parameter int NUM_STEPS = 9,
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              loop_i,
  input  logic              stall_i,
  input  logic              abort_i,
  input  logic              pat_we_i,
  input  logic [CNT_W-1:0]  pat_addr_i,
  input  logic [NUM_CH-1:0] pat_data_i,
  output logic [NUM_CH-1:0] en_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST      = CNT_W'(NUM_STEPS - 1);
  localparam logic [CNT_W:0]   STEPS_EXT = (CNT_W + 1)'(NUM_STEPS);
  // Reset schedule for lane 0, bit i = step i.
  localparam logic [8:0]       DEF_LANE0 = 9'b110100101;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] pat_q [NUM_STEPS];
  logic [NUM_CH-1:0] row;
  logic              pat_wr;

  function automatic logic [NUM_CH-1:0] default_row(input int idx);
    logic [NUM_CH-1:0] r;
    r = '0;
    if (idx < 9) r[0] = DEF_LANE0[idx[3:0]];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake: start_i is taken only in IDLE; busy_o is high for every RUN
  // cycle; done_o pulses for one cycle after the last step of a one-shot run.
  // Abort leaves RUN silently and outranks stall and step advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!stall_i) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (!loop_i) state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A running schedule is frozen; rows past the last step do not exist.
  assign pat_wr = pat_we_i && (state_q != RUN) && ({1'b0, pat_addr_i} < STEPS_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) pat_q[i] <= default_row(i);
    end else if (pat_wr) begin
      pat_q[pat_addr_i] <= pat_data_i;
    end
  end

  assign row    = (cnt_q <= LAST) ? pat_q[cnt_q] : '0;
  assign en_o   = (state_q == RUN) ? (row & {NUM_CH{~stall_i}}) : '0;
  assign cnt_o  = cnt_q;
  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_sa_enable_sequencer.sv
// Bench for sa_enable_sequencer: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_sa_enable_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, loop_i, stall_i, abort_i, pat_we_i;
  logic [3:0] pat_addr_i, pat_data_i;
  logic [3:0] en_o, cnt_o;
  logic       busy_o, done_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] def_l0 = 9'b110100101;

  typedef struct {
    logic       start, loop, stall, abort, we;
    logic [3:0] addr, data;
    logic [3:0] en, cnt;
    logic       busy, done;
  } vec_t;

  vec_t tv[$];

  // reference model state
  bit         m_busy;
  int         m_step;
  bit         m_done;
  logic [3:0] m_pat [9];

  always #5 clk = ~clk;

  sa_enable_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .loop_i(loop_i),
    .stall_i(stall_i), .abort_i(abort_i), .pat_we_i(pat_we_i),
    .pat_addr_i(pat_addr_i), .pat_data_i(pat_data_i),
    .en_o(en_o), .cnt_o(cnt_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string name, input logic [3:0] e_en, input logic [3:0] e_cnt,
                     input logic e_busy, input logic e_done);
    checks++;
    if (en_o !== e_en || cnt_o !== e_cnt || busy_o !== e_busy || done_o !== e_done) begin
      errors++;
      $display("FAIL %s: got en=%b cnt=%0d busy=%b done=%b, expected en=%b cnt=%0d busy=%b done=%b",
               name, en_o, cnt_o, busy_o, done_o, e_en, e_cnt, e_busy, e_done);
    end
  endtask

  task automatic drive(input logic s, input logic l, input logic st, input logic ab,
                       input logic we, input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    start_i = s; loop_i = l; stall_i = st; abort_i = ab;
    pat_we_i = we; pat_addr_i = a; pat_data_i = d;
    #1;
  endtask

  function automatic logic [3:0] def_row(input int k);
    return {3'b000, def_l0[k]};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_step = 0; m_done = 0;
    for (int i = 0; i < 9; i++) m_pat[i] = def_row(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    start_i = 0; loop_i = 0; stall_i = 0; abort_i = 0;
    pat_we_i = 0; pat_addr_i = 0; pat_data_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  function automatic vec_t mk(input logic s, input logic we, input logic [3:0] a,
                              input logic [3:0] d, input logic [3:0] en, input int cnt,
                              input logic busy, input logic done);
    vec_t v;
    v.start = s; v.loop = 0; v.stall = 0; v.abort = 0;
    v.we = we; v.addr = a; v.data = d;
    v.en = en; v.cnt = 4'(cnt); v.busy = busy; v.done = done;
    return v;
  endfunction

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_tick(input logic s, input logic l, input logic st, input logic ab,
                            input logic we, input logic [3:0] a, input logic [3:0] d);
    bit was_done;
    was_done = m_done;
    m_done = 0;
    if (!m_busy && we && a < 9) m_pat[a] = d;
    if (m_busy) begin
      if (ab) begin
        m_busy = 0; m_step = 0;
      end else if (!st) begin
        if (m_step == 8) begin
          m_step = 0;
          if (!l) begin m_busy = 0; m_done = 1; end
        end else m_step++;
      end
    end else if (!was_done && s) begin
      m_busy = 1; m_step = 0;
    end
  endtask

  initial begin
    logic [3:0] row, e_en;
    int         e_cnt;
    logic       st, l, s, ab, we;
    logic [3:0] a, d;

    rst_n = 0;
    start_i = 0; loop_i = 0; stall_i = 0; abort_i = 0;
    pat_we_i = 0; pat_addr_i = 0; pat_data_i = 0;
    #1;
    chk("reset_state", 4'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // one-shot run, IDLE write to step 2, then RUN writes and out-of-range write dropped
    tv.push_back(mk(1, 0, 0, 0, 4'b0, 0, 0, 0));
    for (int k = 0; k < 9; k++) tv.push_back(mk(0, 0, 0, 0, def_row(k), k, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 4'b0, 0, 0, 1));
    tv.push_back(mk(0, 1, 4'd2, 4'b1010, 4'b0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 4'b0, 0, 0, 0));
    for (int k = 0; k < 9; k++)
      tv.push_back(mk(0, 1, 4'(k), 4'b1111, (k == 2) ? 4'b1010 : def_row(k), k, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 4'b0, 0, 0, 1));
    tv.push_back(mk(0, 1, 4'd12, 4'b1111, 4'b0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 4'b0, 0, 0, 0));
    for (int k = 0; k < 9; k++)
      tv.push_back(mk(0, 0, 0, 0, (k == 2) ? 4'b1010 : def_row(k), k, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 4'b0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 4'b0, 0, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].start, tv[i].loop, tv[i].stall, tv[i].abort, tv[i].we, tv[i].addr, tv[i].data);
      chk($sformatf("vec%0d", i), tv[i].en, tv[i].cnt, tv[i].busy, tv[i].done);
    end

    // stall for 3 cycles at step 4: done arrives 3 cycles late
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 13; c++) begin
      st = (c >= 5 && c <= 7);
      drive(0, 0, st, 0, 0, 0, 0);
      if (c == 13) chk("stall_done", 4'b0, 4'd0, 1'b0, 1'b1);
      else begin
        e_cnt = (c <= 5) ? c - 1 : (c <= 8) ? 4 : c - 4;
        e_en  = st ? 4'b0 : def_row(e_cnt);
        chk($sformatf("stall_c%0d", c), e_en, 4'(e_cnt), 1'b1, 1'b0);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("stall_idle", 4'b0, 4'd0, 1'b0, 1'b0);

    // loop: wrap with no bubble, clear loop during second pass step 5
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 19; c++) begin
      l = (c < 15);
      drive(0, l, 0, 0, 0, 0, 0);
      if (c == 19) chk("loop_done", 4'b0, 4'd0, 1'b0, 1'b1);
      else begin
        e_cnt = (c <= 9) ? c - 1 : c - 10;
        chk($sformatf("loop_c%0d", c), def_row(e_cnt), 4'(e_cnt), 1'b1, 1'b0);
      end
    end

    // abort at step 3 while stalled, then start+abort together in IDLE
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0);
    chk("abort_stalled", 4'b0, 4'd3, 1'b1, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("abort_idle", 4'b0, 4'd0, 1'b0, 1'b0);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("abort_no_done", 4'b0, 4'd0, 1'b0, 1'b0);
    for (int c = 0; c <= 9; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (c == 9) chk("restart_done", 4'b0, 4'd0, 1'b0, 1'b1);
      else chk($sformatf("restart_s%0d", c), def_row(c), 4'(c), 1'b1, 1'b0);
    end

    // async reset mid-run restores outputs and default table
    do_reset();
    drive(0, 0, 0, 0, 1, 4'd2, 4'b1111);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 6; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      row = (c == 2) ? 4'b1111 : def_row(c);
      chk($sformatf("prereset_s%0d", c), row, 4'(c), 1'b1, 1'b0);
    end
    #2 rst_n = 0;
    #1 chk("async_reset", 4'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 9; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (c == 9) chk("postreset_done", 4'b0, 4'd0, 1'b0, 1'b1);
      else chk($sformatf("postreset_s%0d", c), def_row(c), 4'(c), 1'b1, 1'b0);
    end

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      s  = ($urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 1) == 0);
      st = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 24) == 0);
      we = ($urandom_range(0, 3) == 0);
      a  = 4'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 15));
      drive(s, l, st, ab, we, a, d);
      e_en = (m_busy && !st) ? m_pat[m_step] : 4'b0;
      chk($sformatf("rand%0d", n), e_en, m_busy ? 4'(m_step) : 4'd0, m_busy, m_done);
      model_tick(s, l, st, ab, we, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
